// File: rtl/proj_gfm_collector.sv
// Receive side of the GFM part stream: decodes one-hot parts back to packed bases,
// reassembles whole fragments and restores the unsigned k-mer index.
module proj_gfm_collector #(
   parameter int FRAG_LEN_BITS     = 64,
   parameter int PART_ONE_HOT      = 32,
   parameter int FRAG_SIZE         = 32,
   parameter int KMER_SIZE         = 16,
   parameter int INDICES_COUNT     = 4,
   parameter int SIGNED_INDICE_LEN = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_first,
   input  logic [SIGNED_INDICE_LEN-1:0] in_index,
   input  logic [PART_ONE_HOT-1:0]      in_gfm,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [FRAG_LEN_BITS-1:0]     out_fragment,
   output logic [SIGNED_INDICE_LEN-2:0] out_index,
   output logic                         out_err,
   output logic                         out_last,
   output logic                         out_drop
);
   localparam int PART_BITS  = PART_ONE_HOT / 2;
   localparam int PARTS      = FRAG_LEN_BITS / PART_BITS;
   localparam int BASES      = PART_ONE_HOT / 4;
   localparam int OFFSET     = (FRAG_SIZE - KMER_SIZE) >> 1;
   localparam int INDICE_LEN = SIGNED_INDICE_LEN - 1;
   localparam int SW         = SIGNED_INDICE_LEN + 1;
   localparam int PCW        = (PARTS > 1) ? $clog2(PARTS) : 1;
   localparam int BCW        = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
   localparam logic [PCW-1:0] LAST_PART = PCW'(PARTS - 1);
   localparam logic [BCW-1:0] LAST_FRAG = BCW'(INDICES_COUNT - 1);

   logic [PCW-1:0]               part_cnt_reg;
   logic [BCW-1:0]               batch_cnt_reg;
   logic [FRAG_LEN_BITS-1:0]     buf_reg;
   logic [SIGNED_INDICE_LEN-1:0] idx_reg;
   logic                         err_acc_reg;

   logic [PART_BITS-1:0]     dec_bits;
   logic [BASES-1:0]         dec_bad;
   logic [SW-1:0]            in_sum;
   logic [INDICE_LEN-1:0]    idx_out_next;
   logic                     range_err, first_err, part_err, accept;
   logic [FRAG_LEN_BITS-1:0] frag_next;

   genvar gi;
   generate
      for (gi = 0; gi < BASES; gi++) begin : g_dec
         logic [1:0] val;
         logic       bad;
         always_comb begin
            val = 2'd0;
            bad = 1'b0;
            case (in_gfm[4*gi +: 4])
               4'b0001: val = 2'd0;
               4'b0010: val = 2'd1;
               4'b0100: val = 2'd2;
               4'b1000: val = 2'd3;
               default: bad = 1'b1;
            endcase
         end
         assign dec_bits[2*gi +: 2] = val;
         assign dec_bad[gi]         = bad;
      end
   endgenerate

   // Sign-extend by one bit so both underflow and overflow of the re-centred index are visible.
   assign in_sum       = {in_index[SIGNED_INDICE_LEN-1], in_index} + SW'(OFFSET);
   assign range_err    = in_sum[SW-1] | (in_sum[SW-2:0] > (SW-1)'(2**INDICE_LEN - 1));
   assign idx_out_next = idx_reg[INDICE_LEN-1:0] + INDICE_LEN'(OFFSET);
   assign first_err    = (|dec_bad) | range_err;
   assign part_err     = first_err | (in_index != idx_reg);

   assign in_ready = !(part_cnt_reg == LAST_PART && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      frag_next = buf_reg;
      frag_next[(PARTS-1)*PART_BITS +: PART_BITS] = dec_bits;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         part_cnt_reg  <= '0;
         batch_cnt_reg <= '0;
         buf_reg       <= '0;
         idx_reg       <= '0;
         err_acc_reg   <= 1'b0;
         out_valid     <= 1'b0;
         out_fragment  <= '0;
         out_index     <= '0;
         out_err       <= 1'b0;
         out_last      <= 1'b0;
         out_drop      <= 1'b0;
      end else begin
         out_drop <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            if (in_first) begin
               // A first part always restarts assembly, discarding any partial fragment.
               out_drop                 <= (part_cnt_reg != '0);
               idx_reg                  <= in_index;
               err_acc_reg              <= first_err;
               buf_reg[PART_BITS-1:0]   <= dec_bits;
               part_cnt_reg             <= PCW'(1);
            end else if (part_cnt_reg == '0) begin
               out_drop <= 1'b1;
            end else if (part_cnt_reg == LAST_PART) begin
               out_fragment  <= frag_next;
               out_index     <= idx_out_next;
               out_err       <= err_acc_reg | part_err;
               out_last      <= (batch_cnt_reg == LAST_FRAG);
               out_valid     <= 1'b1;
               part_cnt_reg  <= '0;
               batch_cnt_reg <= (batch_cnt_reg == LAST_FRAG) ? '0 : batch_cnt_reg + 1'b1;
            end else begin
               buf_reg[part_cnt_reg*PART_BITS +: PART_BITS] <= dec_bits;
               err_acc_reg  <= err_acc_reg | part_err;
               part_cnt_reg <= part_cnt_reg + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_proj_gfm_collector.sv
// Bench for proj_gfm_collector: directed cases plus random traffic, all checked
// every cycle against a part-list reference model.
module tb_proj_gfm_collector;
   localparam logic [31:0] ONE = 32'h1111_1111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_first = 1'b0;
   logic        out_ready = 1'b1;
   logic [8:0]  in_index = '0;
   logic [31:0] in_gfm = ONE;
   logic        in_ready, out_valid, out_err, out_last, out_drop;
   logic [63:0] out_fragment;
   logic [7:0]  out_index;

   int vectors = 0;
   int miscompares = 0;
   bit mon_on = 1'b0;

   always #5 clk = ~clk;

   proj_gfm_collector dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
      .in_index(in_index), .in_gfm(in_gfm),
      .out_valid(out_valid), .out_ready(out_ready), .out_fragment(out_fragment),
      .out_index(out_index), .out_err(out_err), .out_last(out_last), .out_drop(out_drop)
   );

   typedef struct packed {
      logic [63:0] frag;
      logic [7:0]  idx;
      logic        err;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] p_gfm[$];
   int          p_idx[$];
   int          m_batch = 0;
   bit          drop_exp = 1'b0;
   bit          m_rdy;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Whole-fragment view: decode every base, compare every index against the first.
   function automatic exp_t build_frag();
      exp_t        e;
      logic [31:0] g;
      logic [3:0]  n;
      int          v, s;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         if (p_idx[k] != p_idx[0]) e.err = 1'b1;
         g = p_gfm[k];
         for (int i = 0; i < 8; i++) begin
            n = g[4*i +: 4];
            v = (n == 4'd1) ? 0 : (n == 4'd2) ? 1 : (n == 4'd4) ? 2 : (n == 4'd8) ? 3 : -1;
            if (v < 0) begin
               e.err = 1'b1;
               v = 0;
            end
            e.frag[k*16 + 2*i +: 2] = 2'(v);
         end
      end
      s = p_idx[0] + 8;
      if (s < 0 || s > 255) e.err = 1'b1;
      e.idx  = 8'(s & 255);
      e.last = (m_batch == 3);
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         p_gfm.delete();
         p_idx.delete();
         m_batch  = 0;
         drop_exp = 1'b0;
      end else begin
         m_rdy    = !(p_gfm.size() == 3 && exp_q.size() != 0 && !out_ready);
         drop_exp = 1'b0;
         if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
         if (in_valid && m_rdy) begin
            if (in_first) begin
               drop_exp = (p_gfm.size() != 0);
               p_gfm.delete();
               p_idx.delete();
               p_gfm.push_back(in_gfm);
               p_idx.push_back(int'($signed(in_index)));
            end else if (p_gfm.size() == 0) begin
               drop_exp = 1'b1;
            end else begin
               p_gfm.push_back(in_gfm);
               p_idx.push_back(int'($signed(in_index)));
               if (p_gfm.size() == 4) begin
                  exp_q.push_back(build_frag());
                  m_batch = (m_batch + 1) % 4;
                  p_gfm.delete();
                  p_idx.delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         check("in_ready", 64'(in_ready), 64'(!(p_gfm.size() == 3 && exp_q.size() != 0 && !out_ready)));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         check("out_drop", 64'(out_drop), 64'(drop_exp));
         if (exp_q.size() != 0) begin
            check("out_fragment", out_fragment, exp_q[0].frag);
            check("out_index", 64'(out_index), 64'(exp_q[0].idx));
            check("out_err", 64'(out_err), 64'(exp_q[0].err));
            check("out_last", 64'(out_last), 64'(exp_q[0].last));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_part(input bit first, input int idx, input logic [31:0] g);
      bit took;
      took     = 1'b0;
      in_valid = 1'b1;
      in_first = first;
      in_index = 9'(idx);
      in_gfm   = g;
      for (int t = 0; t < 20 && !took; t++) begin
         @(negedge clk);
         took = in_ready;
         step();
      end
      check("part_accepted", 64'(took), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_frag(input int idx, input logic [31:0] g0, g1, g2, g3);
      send_part(1'b1, idx, g0);
      send_part(1'b0, idx, g1);
      send_part(1'b0, idx, g2);
      send_part(1'b0, idx, g3);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [31:0] rand_gfm();
      logic [31:0] g;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 49) == 0) g[4*i +: 4] = 4'($urandom_range(0, 15));
         else g[4*i +: 4] = 4'(1 << $urandom_range(0, 3));
      end
      return g;
   endfunction

   logic [8:0] base_idx = 9'd5;

   initial begin
      rst = 1'b1;
      step(); step(); step();
      mon_on = 1'b1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_fragment", out_fragment, 64'd0);
      check("rst_out_drop", 64'(out_drop), 64'd0);
      rst = 1'b0;
      step();

      // Clean fragment: only part 2 base 0 is non-zero (1000 -> 11 at bits 33:32).
      send_frag(5, ONE, ONE, 32'h1111_1118, ONE);
      check("clean_frag", out_fragment, 64'h0000_0003_0000_0000);
      check("clean_index", 64'(out_index), 64'd13);
      check("clean_err", 64'(out_err), 64'd0);
      check("clean_last", 64'(out_last), 64'd0);

      // Rest of the batch back-to-back, then one more to show the wrap.
      send_frag(7, ONE, ONE, ONE, ONE);
      check("batch_index", 64'(out_index), 64'd15);
      send_frag(7, ONE, ONE, ONE, ONE);
      check("batch_last2", 64'(out_last), 64'd0);
      send_frag(7, ONE, ONE, ONE, ONE);
      check("batch_last3", 64'(out_last), 64'd1);
      send_frag(7, ONE, ONE, ONE, ONE);
      check("batch_wrap", 64'(out_last), 64'd0);
      idle(2);

      // Backpressure: final part of the second fragment stalls behind the held first.
      out_ready = 1'b0;
      send_frag(20, ONE, ONE, ONE, ONE);
      send_part(1'b1, 30, ONE);
      send_part(1'b0, 30, ONE);
      send_part(1'b0, 30, ONE);
      in_valid = 1'b1; in_first = 1'b0; in_index = 9'd30; in_gfm = ONE;
      step(); step();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_index", 64'(out_index), 64'd28);
      out_ready = 1'b1;
      send_part(1'b0, 30, ONE);
      check("bp_second_valid", 64'(out_valid), 64'd1);
      check("bp_second_index", 64'(out_index), 64'd38);
      idle(2);

      // Error cases.
      send_frag(5, ONE, 32'h1111_1161, ONE, ONE);
      check("err_nibble", 64'(out_err), 64'd1);
      send_part(1'b1, 5, ONE);
      send_part(1'b0, 5, ONE);
      send_part(1'b0, 5, ONE);
      send_part(1'b0, 6, ONE);
      check("err_idx_change", 64'(out_err), 64'd1);
      send_frag(-9, ONE, ONE, ONE, ONE);
      check("err_neg", 64'(out_err), 64'd1);
      check("err_neg_index", 64'(out_index), 64'd255);
      send_frag(250, ONE, ONE, ONE, ONE);
      check("err_ovf", 64'(out_err), 64'd1);
      check("err_ovf_index", 64'(out_index), 64'd2);
      idle(2);

      // Framing: restart at part 2, then a stray non-first part.
      send_part(1'b1, 5, ONE);
      send_part(1'b0, 5, ONE);
      send_part(1'b1, 5, ONE);
      check("frame_restart_drop", 64'(out_drop), 64'd1);
      send_part(1'b0, 5, ONE);
      send_part(1'b0, 5, ONE);
      send_part(1'b0, 5, ONE);
      check("frame_restart_valid", 64'(out_valid), 64'd1);
      check("frame_restart_err", 64'(out_err), 64'd0);
      idle(3);
      send_part(1'b0, 5, ONE);
      check("frame_stray_drop", 64'(out_drop), 64'd1);
      step();
      check("frame_stray_nout", 64'(out_valid), 64'd0);

      // Reset in the middle of a fragment.
      send_part(1'b1, 40, ONE);
      send_part(1'b0, 40, ONE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      send_frag(40, ONE, 32'h1111_1121, ONE, ONE);
      check("rst_mid_frag", out_fragment, 64'h0000_0000_0004_0000);
      check("rst_mid_index", 64'(out_index), 64'd48);
      check("rst_mid_last", 64'(out_last), 64'd0);
      idle(2);

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_valid  = ($urandom_range(0, 9) < 8);
         in_first  = ($urandom_range(0, 5) == 0);
         if (in_first)
            base_idx = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 255));
         in_index  = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(0, 511)) : base_idx;
         in_gfm    = rand_gfm();
         step();
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
